// File: rtl/hard_mem_1rw_arb_d1024_w32_pkg.sv
// Shared types and default geometry for the two-port arbitrated 1RW SRAM wrapper.
package hard_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic                      v;
    logic                      w;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_NUM_WMASKS-1:0] mask;
  } mem_req_t;

endpackage

// File: rtl/hard_mem_1rw_arb_d1024_w32_if.sv
// Request/response ports of both requesters plus the SRAM macro pins, bundled for the wrapper.
interface hard_mem_1rw_arb_d1024_w32_if
  import hard_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WMASKS = DEF_NUM_WMASKS
) ();

  logic                  p0_v_i;
  logic                  p0_w_i;
  logic [ADDR_WIDTH-1:0] p0_addr_i;
  logic [DATA_WIDTH-1:0] p0_data_i;
  logic [NUM_WMASKS-1:0] p0_mask_i;
  logic                  p0_ready_o;
  logic                  p0_rv_o;
  logic [DATA_WIDTH-1:0] p0_rdata_o;

  logic                  p1_v_i;
  logic                  p1_w_i;
  logic [ADDR_WIDTH-1:0] p1_addr_i;
  logic [DATA_WIDTH-1:0] p1_data_i;
  logic [NUM_WMASKS-1:0] p1_mask_i;
  logic                  p1_ready_o;
  logic                  p1_rv_o;
  logic [DATA_WIDTH-1:0] p1_rdata_o;

  logic                  init_done_o;
  logic                  mem_csb_o;
  logic                  mem_web_o;
  logic [NUM_WMASKS-1:0] mem_wmask_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_din_o;
  logic [DATA_WIDTH-1:0] mem_dout_i;

  modport slave (
    input  p0_v_i, p0_w_i, p0_addr_i, p0_data_i, p0_mask_i,
    output p0_ready_o, p0_rv_o, p0_rdata_o,
    input  p1_v_i, p1_w_i, p1_addr_i, p1_data_i, p1_mask_i,
    output p1_ready_o, p1_rv_o, p1_rdata_o,
    output init_done_o,
    output mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o, mem_din_o,
    input  mem_dout_i
  );

  modport master (
    output p0_v_i, p0_w_i, p0_addr_i, p0_data_i, p0_mask_i,
    input  p0_ready_o, p0_rv_o, p0_rdata_o,
    output p1_v_i, p1_w_i, p1_addr_i, p1_data_i, p1_mask_i,
    input  p1_ready_o, p1_rv_o, p1_rdata_o,
    input  init_done_o,
    input  mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o, mem_din_o,
    output mem_dout_i
  );

endinterface

// File: rtl/hard_mem_1rw_arb_d1024_w32_rr_arb2.sv
// Two-input round-robin arbiter; the pointer records which port was served last.
module hard_mem_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 = port 1 served last, so port 0 wins the first contested cycle after reset
  logic last_q;

  always_comb begin
    gnt = '0;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/hard_mem_1rw_arb_d1024_w32.sv
// Arbitrated two-port front end for a 1RW hard SRAM macro with power-on zero-fill.
// Build option HARD_MEM_ARB_RDATA_REG_EN adds a register stage on rv/rdata (2-cycle reads).
module hard_mem_1rw_arb_d1024_w32
  import hard_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
  input logic                         clk_i,
  input logic                         reset_n_i,
  hard_mem_1rw_arb_d1024_w32_if.slave bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic                  init_last;
  logic                  run;

  mem_req_t              req0, req1, req_g;
  logic [1:0]            req_v;
  logic [1:0]            gnt;
  logic                  accept;

  logic                  mem_csb;
  logic                  mem_web;
  logic [NUM_WMASKS-1:0] mem_wmask;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;

  logic [1:0]            rd_issue;
  logic [1:0]            rd_pend_q;
  logic [1:0]            rv;
  logic [DATA_WIDTH-1:0] rdata_q [2];
  logic [DATA_WIDTH-1:0] rdata   [2];

  assign req0 = mem_req_t'{v: bus.p0_v_i, w: bus.p0_w_i, addr: bus.p0_addr_i,
                           data: bus.p0_data_i, mask: bus.p0_mask_i};
  assign req1 = mem_req_t'{v: bus.p1_v_i, w: bus.p1_w_i, addr: bus.p1_addr_i,
                           data: bus.p1_data_i, mask: bus.p1_mask_i};

  assign run   = (state_q == RUN);
  assign req_v = {req1.v, req0.v};

  hard_mem_rr_arb2 u_arb (
    .clk   (clk_i),
    .rst_n (reset_n_i),
    .en    (run),
    .req   (req_v),
    .gnt   (gnt)
  );

  assign req_g  = gnt[1] ? req1 : req0;
  assign accept = (|gnt) & req_g.v;

  assign bus.p0_ready_o  = gnt[0];
  assign bus.p1_ready_o  = gnt[1];
  assign bus.init_done_o = run;

  assign init_last = &init_cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // saturates at the last address; only a reset brings the fill back to 0
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      init_cnt_q <= '0;
    end else if (state_q == INIT && !init_last) begin
      init_cnt_q <= init_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_csb   = 1'b1;
    mem_web   = 1'b1;
    mem_wmask = '0;
    mem_addr  = '0;
    mem_din   = '0;
    unique case (state_q)
      INIT: begin
        mem_csb   = 1'b0;
        mem_web   = 1'b0;
        mem_wmask = '1;
        mem_addr  = init_cnt_q;
        if (init_last) state_d = RUN;
      end
      RUN: begin
        if (accept) begin
          mem_csb   = 1'b0;
          mem_web   = ~req_g.w;
          mem_wmask = req_g.mask;
          mem_addr  = req_g.addr;
          mem_din   = req_g.data;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // INIT drives the macro combinationally, so keep it deselected while reset is held
  assign bus.mem_csb_o   = mem_csb | ~reset_n_i;
  assign bus.mem_web_o   = mem_web | ~reset_n_i;
  assign bus.mem_wmask_o = mem_wmask;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_din_o   = mem_din;

  assign rd_issue = gnt & ~{req1.w, req0.w};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_pend_q <= '0;
    end else begin
      rd_pend_q <= rd_issue;
    end
  end

`ifdef HARD_MEM_ARB_RDATA_REG_EN
  logic [1:0] rv_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rv_q <= '0;
      for (int unsigned i = 0; i < 2; i++) rdata_q[i] <= '0;
    end else begin
      rv_q <= rd_pend_q;
      for (int unsigned i = 0; i < 2; i++) begin
        if (rd_pend_q[i]) rdata_q[i] <= bus.mem_dout_i;
      end
    end
  end

  assign rv = rv_q;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) rdata[i] = rdata_q[i];
  end
`else
  assign rv = rd_pend_q;

  // macro output is forwarded during the pulse; the copy holds it afterwards
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < 2; i++) rdata_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (rv[i]) rdata_q[i] <= bus.mem_dout_i;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) rdata[i] = rv[i] ? bus.mem_dout_i : rdata_q[i];
  end
`endif

  assign bus.p0_rv_o    = rv[0];
  assign bus.p1_rv_o    = rv[1];
  assign bus.p0_rdata_o = rdata[0];
  assign bus.p1_rdata_o = rdata[1];

endmodule

// File: tb/tb_hard_mem_1rw_arb_d1024_w32.sv
// Bench for hard_mem_1rw_arb_d1024_w32: behavioural SRAM, transaction-level reference model,
// directed scenarios then random traffic. Honours HARD_MEM_ARB_RDATA_REG_EN for read latency.
module tb_hard_mem_1rw_arb_d1024_w32;
  import hard_mem_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int MW    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef HARD_MEM_ARB_RDATA_REG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  hard_mem_1rw_arb_d1024_w32_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) bus ();

  hard_mem_1rw_arb_d1024_w32 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  // behavioural 1RW macro: write or read at the access edge, dout valid the next cycle
  logic [DW-1:0] sram [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] <= $urandom;
    bus.mem_dout_i <= $urandom;
    forever begin
      @(posedge clk);
      if (!bus.mem_csb_o) begin
        if (!bus.mem_web_o) begin
          for (int b = 0; b < MW; b++)
            if (bus.mem_wmask_o[b]) sram[bus.mem_addr_o][8*b +: 8] <= bus.mem_din_o[8*b +: 8];
        end else begin
          bus.mem_dout_i <= sram[bus.mem_addr_o];
        end
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  typedef struct {
    int            port;
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] gold [DEPTH];
  rsp_t          rsp_q[$];
  logic [DW-1:0] last_rd [2];
  int            ptr_m;
  int            run_k;
  int            cyc;

  logic          obs_rdy [2];
  logic          obs_rv  [2];
  logic [DW-1:0] obs_rdata [2];
  logic          obs_csb;

  task automatic sample_and_check();
    logic          v [2];
    logic          w [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    logic [MW-1:0] m [2];
    logic          erdy [2];
    logic          erv;
    logic [DW-1:0] edata;
    int            sel;
    v[0] = bus.p0_v_i; w[0] = bus.p0_w_i; a[0] = bus.p0_addr_i; d[0] = bus.p0_data_i; m[0] = bus.p0_mask_i;
    v[1] = bus.p1_v_i; w[1] = bus.p1_w_i; a[1] = bus.p1_addr_i; d[1] = bus.p1_data_i; m[1] = bus.p1_mask_i;
    obs_rdy[0] = bus.p0_ready_o; obs_rdy[1] = bus.p1_ready_o;
    obs_rv[0]  = bus.p0_rv_o;    obs_rv[1]  = bus.p1_rv_o;
    obs_rdata[0] = bus.p0_rdata_o; obs_rdata[1] = bus.p1_rdata_o;
    obs_csb = bus.mem_csb_o;

    if (!rst_n) begin
      check("rst_csb", bus.mem_csb_o, 1);
      check("rst_web", bus.mem_web_o, 1);
      check("rst_rdy0", obs_rdy[0], 0);
      check("rst_rdy1", obs_rdy[1], 0);
      check("rst_done", bus.init_done_o, 0);
      check("rst_rv0", obs_rv[0], 0);
      check("rst_rv1", obs_rv[1], 0);
      check("rst_rdata0", obs_rdata[0], 0);
      check("rst_rdata1", obs_rdata[1], 0);
      rsp_q.delete();
      ptr_m = 1;
      run_k = -1;
      last_rd[0] = '0;
      last_rd[1] = '0;
      for (int i = 0; i < DEPTH; i++) gold[i] = '0;
      return;
    end

    if (run_k < DEPTH) begin
      check("init_rdy0", obs_rdy[0], 0);
      check("init_rdy1", obs_rdy[1], 0);
      check("init_done_low", bus.init_done_o, 0);
      check("init_csb", bus.mem_csb_o, 0);
      check("init_web", bus.mem_web_o, 0);
      check("init_addr", bus.mem_addr_o, 64'(run_k));
      check("init_din", bus.mem_din_o, 0);
      check("init_wmask", bus.mem_wmask_o, 4'hF);
    end else begin
      check("done_high", bus.init_done_o, 1);
      erdy[0] = v[0] && (!v[1] || ptr_m == 1);
      erdy[1] = v[1] && (!v[0] || ptr_m == 0);
      check("rdy0", obs_rdy[0], erdy[0]);
      check("rdy1", obs_rdy[1], erdy[1]);
      if (erdy[0] || erdy[1]) begin
        sel = erdy[1] ? 1 : 0;
        check("acc_csb", bus.mem_csb_o, 0);
        check("acc_web", bus.mem_web_o, !w[sel]);
        check("acc_addr", bus.mem_addr_o, a[sel]);
        check("acc_din", bus.mem_din_o, d[sel]);
        check("acc_wmask", bus.mem_wmask_o, m[sel]);
        if (w[sel]) begin
          for (int b = 0; b < MW; b++)
            if (m[sel][b]) gold[a[sel]][8*b +: 8] = d[sel][8*b +: 8];
        end else begin
          rsp_q.push_back('{port: sel, due: cyc + RD_LAT, data: gold[a[sel]]});
        end
        ptr_m = sel;
      end else begin
        check("idle_csb", bus.mem_csb_o, 1);
        check("idle_web", bus.mem_web_o, 1);
      end
    end

    for (int p = 0; p < 2; p++) begin
      erv   = 1'b0;
      edata = '0;
      foreach (rsp_q[i]) begin
        if (rsp_q[i].port == p && rsp_q[i].due == cyc) begin
          erv   = 1'b1;
          edata = rsp_q[i].data;
        end
      end
      check(p == 0 ? "rv0" : "rv1", obs_rv[p], erv);
      if (erv) begin
        check(p == 0 ? "rdata0" : "rdata1", obs_rdata[p], edata);
        last_rd[p] = edata;
      end else begin
        check(p == 0 ? "rdata0_hold" : "rdata1_hold", obs_rdata[p], last_rd[p]);
      end
    end
    while (rsp_q.size() > 0 && rsp_q[0].due <= cyc) void'(rsp_q.pop_front());
  endtask

  // inputs are driven just after the edge; everything is sampled at the falling edge
  task automatic tick();
    @(negedge clk);
    sample_and_check();
    @(posedge clk);
    #1;
    cyc++;
    run_k++;
  endtask

  task automatic drive(input int p, input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [MW-1:0] m);
    if (p == 0) begin
      bus.p0_v_i = v; bus.p0_w_i = w; bus.p0_addr_i = a; bus.p0_data_i = d; bus.p0_mask_i = m;
    end else begin
      bus.p1_v_i = v; bus.p1_w_i = w; bus.p1_addr_i = a; bus.p1_data_i = d; bus.p1_mask_i = m;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
  endtask

  task automatic wait_rv(input int p, output int lat, output logic [DW-1:0] data);
    lat  = 0;
    data = '0;
    for (int i = 1; i <= RD_LAT + 3 && lat == 0; i++) begin
      tick();
      if (obs_rv[p]) begin
        lat  = i;
        data = obs_rdata[p];
      end
    end
  endtask

  int            lat;
  logic [DW-1:0] rd;
  logic [5:0]    gseq;
  int            rvc0, rvc1, csb_lo, rdy1_cnt;

  initial begin
    cyc   = 0;
    run_k = 0;
    ptr_m = 1;
    idle();
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // zero-fill with both ports requesting, then first contested grant
    drive(0, 1, 0, 5, '0, '0);
    drive(1, 1, 0, 7, '0, '0);
    repeat (DEPTH) tick();
    tick();
    check("first_gnt_p0", obs_rdy[0], 1);
    check("first_gnt_p1", obs_rdy[1], 0);
    idle();
    repeat (RD_LAT + 1) tick();

    // masked write then cross-port read
    drive(0, 1, 1, 5, 32'hDEADBEEF, 4'b0101);
    tick();
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 1, 0, 5, '0, '0);
    tick();
    check("rd_acc_p1", obs_rdy[1], 1);
    idle();
    wait_rv(1, lat, rd);
    check("rd_lat_p1", 64'(lat), 64'(RD_LAT));
    check("rd_data_p1", rd, 32'h00AD00EF);

    // contested back-to-back reads
    rvc0 = 0; rvc1 = 0; csb_lo = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, AW'($urandom_range(0, 15)), '0, '0);
      drive(1, 1, 0, AW'($urandom_range(0, 15)), '0, '0);
      tick();
      gseq[i] = obs_rdy[1];
      rvc0 += int'(obs_rv[0]);
      rvc1 += int'(obs_rv[1]);
      csb_lo += int'(!obs_csb);
    end
    idle();
    repeat (RD_LAT + 1) begin
      tick();
      rvc0 += int'(obs_rv[0]);
      rvc1 += int'(obs_rv[1]);
    end
    check("alt_gnt_seq", gseq, 6'b101010);
    check("alt_rv0_cnt", 64'(rvc0), 3);
    check("alt_rv1_cnt", 64'(rvc1), 3);
    check("alt_csb_busy", 64'(csb_lo), 6);

    // lone port-1 writes move the pointer to port 1
    drive(0, 1, 0, 3, '0, '0);
    tick();
    idle();
    rdy1_cnt = 0; rvc1 = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, AW'(DEPTH - 1), $urandom, 4'($urandom_range(0, 15)));
      tick();
      rdy1_cnt += int'(obs_rdy[1]);
      if (i >= RD_LAT) rvc1 += int'(obs_rv[1]);
    end
    check("p1_only_rdy_cnt", 64'(rdy1_cnt), 5);
    check("p1_only_no_rv", 64'(rvc1), 0);
    drive(0, 1, 0, AW'(DEPTH - 1), '0, '0);
    drive(1, 1, 0, 2, '0, '0);
    tick();
    check("after_p1_gnt_p0", obs_rdy[0], 1);
    check("after_p1_gnt_p1", obs_rdy[1], 0);
    idle();
    repeat (RD_LAT + 1) tick();

    // reset one cycle after an accepted port-0 read
    drive(0, 1, 0, 5, '0, '0);
    tick();
    check("pre_rst_acc", obs_rdy[0], 1);
    idle();
    rst_n = 1'b0;
    tick();
    check("rst_drop_rv0", obs_rv[0], 0);
    check("rst_csb_high", obs_csb, 1);
    rst_n = 1'b1;
    rvc0 = 0;
    repeat (DEPTH) begin
      tick();
      rvc0 += int'(obs_rv[0]);
    end
    check("reinit_no_rv0", 64'(rvc0), 0);
    drive(0, 1, 0, 5, '0, '0);
    tick();
    idle();
    wait_rv(0, lat, rd);
    check("reinit_lat", 64'(lat), 64'(RD_LAT));
    check("reinit_rd5", rd, 0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 2; p++)
        drive(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 7)),
              $urandom, 4'($urandom_range(0, 15)));
      tick();
    end
    idle();
    repeat (RD_LAT + 2) tick();
    check("rsp_drained", 64'(rsp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hard_mem_1rw_arb_d1024_w32.md
HARD_MEM_1RW_ARB_D1024_W32 -- requirements
Module: hard_mem_1rw_arb_d1024_w32

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word address width (1024 words).
REQ-002 Parameter DATA_WIDTH, default 32, word width.
REQ-003 Parameter NUM_WMASKS, default 4, byte-enable width (DATA_WIDTH/8).
REQ-004 The block SHALL have these ports (clock and reset first):
- clk_i  in  1  sole clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- p{0,1}_v_i  in  1  request valid.
- p{0,1}_w_i  in  1  1 = write, 0 = read.
- p{0,1}_addr_i  in  ADDR_WIDTH  word address.
- p{0,1}_data_i  in  DATA_WIDTH  write data.
- p{0,1}_mask_i  in  NUM_WMASKS  byte enable, active high.
- p{0,1}_ready_o  out  1  request accepted this cycle when high together with v_i.
- p{0,1}_rv_o  out  1  read-data valid pulse.
- p{0,1}_rdata_o  out  DATA_WIDTH  read data.
- init_done_o  out  1  zero-fill complete.
- mem_csb_o  out  1  SRAM chip select, active low.
- mem_web_o  out  1  SRAM write enable, active low.
- mem_wmask_o  out  NUM_WMASKS  SRAM byte mask.
- mem_addr_o  out  ADDR_WIDTH  SRAM address.
- mem_din_o  out  DATA_WIDTH  SRAM write data.
- mem_dout_i  in  DATA_WIDTH  SRAM read data, valid in the cycle after the access edge.

Function
REQ-005 The FSM SHALL have two states, INIT and RUN; reset enters INIT.
REQ-006 In INIT, the block SHALL write zero to addresses 0 through 1023, one per cycle, with mem_wmask_o all ones; ready_o SHALL be 0 on both ports.
REQ-007 After writing address 1023, the FSM SHALL go to RUN on the next edge and assert init_done_o from then on; the INIT counter width SHALL be ADDR_WIDTH and it SHALL NOT wrap back into INIT.
REQ-008 In RUN with exactly one port valid, that port SHALL be granted (ready_o = 1) combinationally in the same cycle.
REQ-009 In RUN with both ports valid, the port opposite the round-robin pointer's last-served port SHALL be granted; the other port's ready_o SHALL be 0.
REQ-010 The round-robin pointer SHALL update only on an accepted transaction (v_i & ready_o), and SHALL hold when no port is valid.
REQ-011 An accepted request SHALL drive the mem_* outputs in the same cycle: csb = 0, web = ~w, with addr, data and mask passed through from the granted port.
REQ-012 When there is no accepted request and the FSM is in RUN, mem_csb_o SHALL be 1 and mem_web_o SHALL be 1.
REQ-013 A read SHALL raise rv_o on the issuing port exactly 1 cycle after acceptance, with rdata_o = mem_dout_i; a write SHALL produce no rv_o.
REQ-014 Back-to-back reads, including alternating ports, SHALL be accepted every cycle with no bubble.
REQ-015 rv_o SHALL be a single-cycle pulse with no backpressure, and the requester SHALL be ready to take it.
REQ-016 rdata_o SHALL hold its last value when rv_o is 0.

Reset
REQ-017 Asserting reset_n_i low SHALL immediately set: FSM = INIT, init counter = 0, pointer = port 1 (so port 0 wins first), init_done_o = 0, ready_o = 0, rv_o = 0, rdata_o = 0, mem_csb_o = 1, mem_web_o = 1.
REQ-018 Reset asserted mid-operation SHALL discard any in-flight read response (no rv_o) and restart the zero-fill from address 0.

Configuration
REQ-019 With HARD_MEM_ARB_RDATA_REG_EN defined, an extra register stage SHALL be added on rdata_o and rv_o, giving a read latency of 2 cycles with full throughput preserved.
REQ-020 Without HARD_MEM_ARB_RDATA_REG_EN, the read latency SHALL be 1 cycle as in REQ-013.

Structure
REQ-021 The package hard_mem_pkg SHALL hold the FSM state enum (INIT, RUN), a request struct type (v, w, addr, data, mask), and the default ADDR_WIDTH, DATA_WIDTH and NUM_WMASKS constants.
REQ-022 The block SHALL contain one sub-module, hard_mem_rr_arb2, a two-input round-robin arbiter holding the pointer; it SHALL be instantiated once.

Verification
REQ-023 The bench SHALL release reset and hold both ports valid. Required: ready_o = 0 on both ports for 1024 cycles, mem_addr_o steps 0 to 1023 with web = 0 and din = 0, init_done_o rises at cycle 1025, and the first grant goes to port 0.
REQ-024 After init, the bench SHALL write 0xDEADBEEF with mask 4'b0101 to addr 5 on port 0, then read addr 5 on port 1. Required: p1_rv_o one cycle after acceptance with rdata 0x00AD00EF.
REQ-025 The bench SHALL hold both ports valid with reads for 6 cycles. Required: grants alternate 0,1,0,1,0,1, each port gets 3 rv_o pulses, and there are no idle cycles on mem_csb_o.
REQ-026 The bench SHALL assert reset_n_i for one cycle in the cycle after a port 0 read is accepted. Required: no p0_rv_o, mem_csb_o = 1 during reset, zero-fill restarts at addr 0, and the addr-5 read after re-init returns 0.
REQ-027 The bench SHALL repeat REQ-024 with HARD_MEM_ARB_RDATA_REG_EN defined. Required: rv_o arrives 2 cycles after acceptance, and reads on consecutive cycles still complete one per cycle.
REQ-028 The bench SHALL hold only port 1 valid with writes to addr 1023. Required: ready_o = 1 every cycle, no rv_o, and the pointer stays on port 1, so a later simultaneous request is granted to port 0.
